// File: rtl/muldiv_sequencer_if.sv
// Handshake, result and ALU time-share signals between the pipeline and muldiv_sequencer.
// The slave modport is the sequencer's view; master is the pipeline/ALU side.
interface muldiv_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start_i;
    logic                  op_i;
    logic [DATA_WIDTH-1:0] rs_i;
    logic [DATA_WIDTH-1:0] rt_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  div_by_zero_o;
    logic [DATA_WIDTH-1:0] hi_o;
    logic [DATA_WIDTH-1:0] lo_o;
    logic [3:0]            alu_operation_o;
    logic [DATA_WIDTH-1:0] alu_a_o;
    logic [DATA_WIDTH-1:0] alu_b_o;
    logic [DATA_WIDTH-1:0] alu_data_i;

    modport slave (
        input  start_i,
        input  op_i,
        input  rs_i,
        input  rt_i,
        input  alu_data_i,
        output busy_o,
        output done_o,
        output div_by_zero_o,
        output hi_o,
        output lo_o,
        output alu_operation_o,
        output alu_a_o,
        output alu_b_o
    );

    modport master (
        output start_i,
        output op_i,
        output rs_i,
        output rt_i,
        output alu_data_i,
        input  busy_o,
        input  done_o,
        input  div_by_zero_o,
        input  hi_o,
        input  lo_o,
        input  alu_operation_o,
        input  alu_a_o,
        input  alu_b_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer: one shift-add or restoring-divide step per clock,
// borrowing the shared single-cycle ALU for the add/subtract of each step.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [3:0]  ADD_OP     = 4'b0011,
    parameter logic [3:0]  SUB_OP     = 4'b0101
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                r_state;
    logic                  r_op;
    logic [DATA_WIDTH-1:0] r_opd;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [CntW-1:0]       r_count;
    logic                  r_dbz;

    state_e                w_state_next;
    logic                  w_op_next;
    logic [DATA_WIDTH-1:0] w_opd_next;
    logic [DATA_WIDTH-1:0] w_hi_next;
    logic [DATA_WIDTH-1:0] w_lo_next;
    logic [CntW-1:0]       w_count_next;
    logic                  w_dbz_next;

    logic [3:0]            w_alu_op;
    logic [DATA_WIDTH-1:0] w_alu_a;
    logic [DATA_WIDTH-1:0] w_alu_b;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_carry;
    logic [DATA_WIDTH-1:0] w_sh;
    logic                  w_msb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_op    <= 1'b0;
            r_opd   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_count <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_opd   <= w_opd_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_count <= w_count_next;
            r_dbz   <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_opd_next   = r_opd;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_count_next = r_count;
        w_dbz_next   = r_dbz;
        w_alu_op     = ADD_OP;
        w_alu_a      = '0;
        w_alu_b      = '0;
        w_sum        = r_hi;
        w_carry      = 1'b0;
        // Divide step shifts the next dividend bit out of LO into the partial remainder.
        w_sh         = {r_hi[DATA_WIDTH-2:0], r_lo[DATA_WIDTH-1]};
        w_msb        = r_hi[DATA_WIDTH-1];

        case (r_state)
            StIdle: begin
                if (bus.start_i) begin
                    w_op_next  = bus.op_i;
                    w_opd_next = bus.rt_i;
                    w_hi_next  = '0;
                    w_lo_next  = bus.rs_i;
                    if (bus.op_i && (bus.rt_i == '0)) begin
                        w_state_next = StDone;
                        w_hi_next    = bus.rs_i;
                        w_lo_next    = '1;
                        w_dbz_next   = 1'b1;
                    end else begin
                        w_state_next = StRun;
                        w_count_next = '0;
                        w_dbz_next   = 1'b0;
                    end
                end
            end

            StRun: begin
                w_count_next = r_count + CntW'(1);
                if (r_count == LastCnt) begin
                    w_state_next = StDone;
                end
                if (!r_op) begin
                    w_alu_op = ADD_OP;
                    w_alu_a  = r_hi;
                    w_alu_b  = r_opd;
                    if (r_lo[0]) begin
                        w_sum   = bus.alu_data_i;
                        // Unsigned wrap of the ALU sum recovers the carry-out.
                        w_carry = (bus.alu_data_i < r_hi);
                    end
                    w_hi_next = {w_carry, w_sum[DATA_WIDTH-1:1]};
                    w_lo_next = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
                end else begin
                    w_alu_op = SUB_OP;
                    w_alu_a  = w_sh;
                    w_alu_b  = r_opd;
                    if (w_msb || (w_sh >= r_opd)) begin
                        w_hi_next = bus.alu_data_i;
                        w_lo_next = {r_lo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        w_hi_next = w_sh;
                        w_lo_next = {r_lo[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end

            StDone: begin
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign bus.busy_o          = (r_state != StIdle);
    assign bus.done_o          = (r_state == StDone);
    assign bus.div_by_zero_o   = r_dbz;
    assign bus.hi_o            = r_hi;
    assign bus.lo_o            = r_lo;
    assign bus.alu_operation_o = w_alu_op;
    assign bus.alu_a_o         = w_alu_a;
    assign bus.alu_b_o         = w_alu_b;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural add/sub ALU beside it.
module tb_muldiv_sequencer;

    localparam logic [3:0] AddOp = 4'b0011;
    localparam logic [3:0] SubOp = 4'b0101;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

    muldiv_sequencer #(
        .DATA_WIDTH(32),
        .ADD_OP    (AddOp),
        .SUB_OP    (SubOp)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always_comb begin
        case (bus.alu_operation_o)
            AddOp:   bus.alu_data_i = bus.alu_a_o + bus.alu_b_o;
            SubOp:   bus.alu_data_i = bus.alu_a_o - bus.alu_b_o;
            default: bus.alu_data_i = 32'h0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation. inject_at pulses a second start mid-run; reset_at aborts with reset.
    // lat returns the edge count (start-sampling edge = 1) at which done_o was seen, or -1.
    task automatic run_op(input logic op, input logic [31:0] rs, input logic [31:0] rt,
                          input int inject_at, input int reset_at,
                          output int lat, output int busy_low);
        lat      = -1;
        busy_low = 0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs_i    = rs;
        bus.rt_i    = rt;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (n == inject_at) begin
                bus.start_i = 1'b1;
                bus.op_i    = ~op;
                bus.rs_i    = 32'd123;
                bus.rt_i    = 32'd11;
            end
            if (n == reset_at) begin
                reset = 1'b0;
                #1;
                break;
            end
            if (!bus.busy_o) busy_low++;
            if (bus.done_o) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_done_drop(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {63'h0, bus.done_o}, 64'h0);
        check({tag, "_busy_idle"}, {63'h0, bus.busy_o}, 64'h0);
    endtask

    int lat;
    int busy_low;
    int done_seen;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 1'b0;
        bus.rs_i    = 32'h0;
        bus.rt_i    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, bus.busy_o}, 64'h0);
        check("rst_done", {63'h0, bus.done_o}, 64'h0);
        check("rst_dbz", {63'h0, bus.div_by_zero_o}, 64'h0);
        check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        check("rst_alu_op", {60'h0, bus.alu_operation_o}, {60'h0, AddOp});
        check("rst_alu_ab", {bus.alu_a_o, bus.alu_b_o}, 64'h0);
        reset = 1'b1;

        run_op(1'b0, 32'd7, 32'd6, 0, 0, lat, busy_low);
        check("mul7x6_lat", 64'(lat), 64'd33);
        check("mul7x6_busy", 64'(busy_low), 64'd0);
        check("mul7x6_hilo", {bus.hi_o, bus.lo_o}, 64'd42);
        check("mul7x6_dbz", {63'h0, bus.div_by_zero_o}, 64'h0);
        check_done_drop("mul7x6");

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat, busy_low);
        check("mulmax_lat", 64'(lat), 64'd33);
        check("mulmax_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
        check_done_drop("mulmax");
        check("mulmax_hold", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);

        run_op(1'b1, 32'd100, 32'd7, 0, 0, lat, busy_low);
        check("div100_lat", 64'(lat), 64'd33);
        check("div100_hilo", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});

        run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, lat, busy_low);
        check("divmsb_hilo", {bus.hi_o, bus.lo_o}, {32'h7FFF_FFFF, 32'd1});
        check_done_drop("divmsb");

        run_op(1'b1, 32'd5, 32'd0, 0, 0, lat, busy_low);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_flag", {63'h0, bus.div_by_zero_o}, 64'h1);
        check("div0_hilo", {bus.hi_o, bus.lo_o}, {32'd5, 32'hFFFF_FFFF});
        check_done_drop("div0");
        check("div0_sticky", {63'h0, bus.div_by_zero_o}, 64'h1);

        run_op(1'b0, 32'd3, 32'd3, 10, 0, lat, busy_low);
        check("mul3x3_lat", 64'(lat), 64'd33);
        check("mul3x3_busy", 64'(busy_low), 64'd0);
        check("mul3x3_hilo", {bus.hi_o, bus.lo_o}, 64'd9);
        check("mul3x3_dbz_clr", {63'h0, bus.div_by_zero_o}, 64'h0);
        check_done_drop("mul3x3");

        run_op(1'b1, 32'd1000, 32'd3, 0, 15, lat, busy_low);
        check("abort_no_done", 64'(lat), -64'sd1);
        check("abort_busy", {63'h0, bus.busy_o}, 64'h0);
        check("abort_done", {63'h0, bus.done_o}, 64'h0);
        check("abort_dbz", {63'h0, bus.div_by_zero_o}, 64'h0);
        check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
        check("abort_alu_ab", {bus.alu_a_o, bus.alu_b_o}, 64'h0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done_o) done_seen++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done_o || bus.busy_o) done_seen++;
        end
        check("abort_quiet", 64'(done_seen), 64'd0);

        run_op(1'b0, 32'd2, 32'd2, 0, 0, lat, busy_low);
        check("mul2x2_lat", 64'(lat), 64'd33);
        check("mul2x2_hilo", {bus.hi_o, bus.lo_o}, 64'd4);
        check_done_drop("mul2x2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
